// File: rtl/gpio_wb_irq_pkg.sv
// Shared Wishbone bundle definitions and GPIO register map for the
// peripheral interconnect. Firmware headers mirror the offsets below.

`ifndef GPIO_WB_IRQ_WB_DEFS
`define GPIO_WB_IRQ_WB_DEFS
// Master-to-slave bundle: {addr[31:0], data[31:0], sel[3:0], we, stb, cyc}
`define WB_M2S   logic [70:0]
// Slave-to-master bundle: {data[31:0], ack}
`define WB_S2M   logic [32:0]
`define WB_ADDR  70:39
`define WB_WDATA 38:7
`define WB_SEL   6:3
`define WB_WE    2
`define WB_STB   1
`define WB_CYC   0
`define WB_RDATA 32:1
`define WB_ACK   0
`endif

package gpio_wb_irq_pkg;

    localparam int WB_M2S_W = 71;
    localparam int WB_S2M_W = 33;

    // Byte offsets of the GPIO registers
    localparam logic [31:0] GPIO_DATA_OUT   = 32'h00;
    localparam logic [31:0] GPIO_DIR        = 32'h04;
    localparam logic [31:0] GPIO_DATA_IN    = 32'h08;
    localparam logic [31:0] GPIO_IRQ_EN     = 32'h0C;
    localparam logic [31:0] GPIO_IRQ_RISE   = 32'h10;
    localparam logic [31:0] GPIO_IRQ_FALL   = 32'h14;
    localparam logic [31:0] GPIO_IRQ_STATUS = 32'h18;
    localparam logic [31:0] GPIO_RESERVED   = 32'h1C;

    // A single flop is not a synchroniser
    localparam int SYNC_MIN_STAGES = 2;

    // Word index decoded from addr[4:2]
    typedef enum logic [2:0] {
        REG_DATA_OUT   = 3'd0,
        REG_DIR        = 3'd1,
        REG_DATA_IN    = 3'd2,
        REG_IRQ_EN     = 3'd3,
        REG_IRQ_RISE   = 3'd4,
        REG_IRQ_FALL   = 3'd5,
        REG_IRQ_STATUS = 3'd6,
        REG_RSVD       = 3'd7
    } gpio_reg_e;

    // Expand Wishbone byte selects into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_wb_irq_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs. Generic width so the
// UART RX pin can reuse it.

module gpio_sync
    import gpio_wb_irq_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    // Depth is clamped so a mis-set parameter never yields a single flop
    localparam int DEPTH = (STAGES < SYNC_MIN_STAGES) ? SYNC_MIN_STAGES : STAGES;

    logic [WIDTH-1:0] sync_p [DEPTH];

    // Shift the pad value through the flop chain
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int s = 0; s < DEPTH; s++) begin
                sync_p[s] <= '0;
            end
        end else begin
            sync_p[0] <= i_async;
            for (int s = 1; s < DEPTH; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
        end
    end

    assign o_sync = sync_p[DEPTH-1];

endmodule

// File: rtl/gpio_wb_irq.sv
// Wishbone-slave GPIO controller: output/direction registers, synchronised
// inputs, per-pin rise/fall interrupts with write-1-to-clear status and a
// single level interrupt line. Every access is acked one cycle later.

module gpio_wb_irq
    import gpio_wb_irq_pkg::*;
#(
    parameter int          N_GPIO      = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RST_OUT     = 32'h0,
    parameter logic [31:0] RST_DIR     = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  `WB_M2S            i_m2s_wb,
    output `WB_S2M            o_s2m_wb,
    input  logic [N_GPIO-1:0] i_gpio,
    output logic [N_GPIO-1:0] o_gpio,
    output logic [N_GPIO-1:0] o_gpio_oe,
    output logic              o_irq
);

    // Bits above N_GPIO are never stored, so they read back as 0
    localparam logic [31:0] PIN_MASK = (N_GPIO >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'h1 << N_GPIO) - 32'h1);

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic        unused_addr;

    assign wb_addr     = i_m2s_wb[`WB_ADDR];
    assign wb_wdata    = i_m2s_wb[`WB_WDATA];
    assign wb_sel      = i_m2s_wb[`WB_SEL];
    assign wb_we       = i_m2s_wb[`WB_WE];
    assign wb_stb      = i_m2s_wb[`WB_STB];
    assign wb_cyc      = i_m2s_wb[`WB_CYC];
    assign unused_addr = ^{wb_addr[31:5], wb_addr[1:0]};

    logic        ack_p1;
    logic [31:0] rd_data_p1;
    logic [31:0] rd_mux;
    logic        req;
    logic        wr_req;
    logic [31:0] wmask;
    gpio_reg_e   reg_sel;

    logic [31:0] data_out_q;
    logic [31:0] dir_q;
    logic [31:0] irq_en_q;
    logic [31:0] irq_rise_q;
    logic [31:0] irq_fall_q;
    logic [31:0] status_q;
    logic        irq_q;

    logic [N_GPIO-1:0] sync_in;
    logic [31:0]       sync_ext;
    logic [31:0]       prev_q;
    logic [31:0]       rise;
    logic [31:0]       fall;
    logic [31:0]       set_bits;
    logic [31:0]       w1c_mask;

    // A pending ack blocks a second request in the same access
    assign req     = wb_stb & wb_cyc & ~ack_p1;
    assign wr_req  = req & wb_we;
    assign wmask   = lane_mask(wb_sel) & PIN_MASK;
    assign reg_sel = gpio_reg_e'(wb_addr[4:2]);

    // ---- stage 0: pad synchroniser ----
    gpio_sync #(
        .WIDTH  (N_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_async (i_gpio),
        .o_sync  (sync_in)
    );

    // Zero-extend the synchronised pins to register width
    always_comb begin
        sync_ext              = '0;
        sync_ext[N_GPIO-1:0]  = sync_in;
    end

    // ---- stage 1: edge detection against the previous sample ----
    // Remember last cycle's synchronised value for edge detection
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_ext;
        end
    end

    assign rise     = sync_ext & ~prev_q;
    assign fall     = ~sync_ext & prev_q;
    assign set_bits = irq_en_q & ((rise & irq_rise_q) | (fall & irq_fall_q));
    assign w1c_mask = (wr_req && reg_sel == REG_IRQ_STATUS) ? (wb_wdata & wmask) : '0;

    // Configuration registers, byte-lane writes on the request edge
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_out_q <= RST_OUT & PIN_MASK;
            dir_q      <= RST_DIR & PIN_MASK;
            irq_en_q   <= '0;
            irq_rise_q <= '0;
            irq_fall_q <= '0;
        end else if (wr_req) begin
            case (reg_sel)
                REG_DATA_OUT: data_out_q <= merge(data_out_q, wb_wdata, wmask);
                REG_DIR:      dir_q      <= merge(dir_q,      wb_wdata, wmask);
                REG_IRQ_EN:   irq_en_q   <= merge(irq_en_q,   wb_wdata, wmask);
                REG_IRQ_RISE: irq_rise_q <= merge(irq_rise_q, wb_wdata, wmask);
                REG_IRQ_FALL: irq_fall_q <= merge(irq_fall_q, wb_wdata, wmask);
                default:      ;
            endcase
        end
    end

    // Sticky status: a new edge wins over a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~w1c_mask) | set_bits;
        end
    end

    // ---- stage 2: interrupt line, one cycle behind status ----
    // Level interrupt from enabled pending bits
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status_q & irq_en_q);
        end
    end

    // Read multiplexer over the current register values
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_DATA_OUT:   rd_mux = data_out_q;
            REG_DIR:        rd_mux = dir_q;
            REG_DATA_IN:    rd_mux = sync_ext;
            REG_IRQ_EN:     rd_mux = irq_en_q;
            REG_IRQ_RISE:   rd_mux = irq_rise_q;
            REG_IRQ_FALL:   rd_mux = irq_fall_q;
            REG_IRQ_STATUS: rd_mux = status_q;
            default:        rd_mux = '0;
        endcase
    end

    // Registered one-cycle ack; read data is only non-zero alongside ack
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ack_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            ack_p1     <= req;
            rd_data_p1 <= req ? rd_mux : '0;
        end
    end

    assign o_s2m_wb[`WB_RDATA] = rd_data_p1;
    assign o_s2m_wb[`WB_ACK]   = ack_p1;
    assign o_gpio              = data_out_q[N_GPIO-1:0];
    assign o_gpio_oe           = dir_q[N_GPIO-1:0];
    assign o_irq               = irq_q;

endmodule

// File: tb/tb_gpio_wb_irq.sv
// Directed bench for gpio_wb_irq: a register-access vector table on a
// 32-pin instance, hand-written interrupt sequences, and an 8-pin instance.

module tb_gpio_wb_irq;
    import gpio_wb_irq_pkg::*;

    localparam int SYNC_N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-pin instance with non-zero reset values
    logic                rstn_a;
    logic [WB_M2S_W-1:0] m2s_a;
    logic [WB_S2M_W-1:0] s2m_a;
    logic [31:0]         gpio_in_a;
    logic [31:0]         gpio_out_a;
    logic [31:0]         gpio_oe_a;
    logic                irq_a;

    // 8-pin instance with default reset values
    logic                rstn_b;
    logic [WB_M2S_W-1:0] m2s_b;
    logic [WB_S2M_W-1:0] s2m_b;
    logic [7:0]          gpio_in_b;
    logic [7:0]          gpio_out_b;
    logic [7:0]          gpio_oe_b;
    logic                irq_b;

    gpio_wb_irq #(
        .N_GPIO      (32),
        .SYNC_STAGES (SYNC_N),
        .RST_OUT     (32'h0000_00A5),
        .RST_DIR     (32'h0000_00FF)
    ) dut_a (
        .i_clk     (clk),
        .i_rstn    (rstn_a),
        .i_m2s_wb  (m2s_a),
        .o_s2m_wb  (s2m_a),
        .i_gpio    (gpio_in_a),
        .o_gpio    (gpio_out_a),
        .o_gpio_oe (gpio_oe_a),
        .o_irq     (irq_a)
    );

    gpio_wb_irq #(
        .N_GPIO      (8),
        .SYNC_STAGES (SYNC_N),
        .RST_OUT     (32'h0),
        .RST_DIR     (32'h0)
    ) dut_b (
        .i_clk     (clk),
        .i_rstn    (rstn_b),
        .i_m2s_wb  (m2s_b),
        .o_s2m_wb  (s2m_b),
        .i_gpio    (gpio_in_b),
        .o_gpio    (gpio_out_b),
        .o_gpio_oe (gpio_oe_b),
        .o_irq     (irq_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [31:0] exp_gpio;
        logic [31:0] exp_oe;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    function automatic logic ack_of(input int which);
        return (which == 0) ? s2m_a[0] : s2m_b[0];
    endfunction

    function automatic logic [31:0] rd_of(input int which);
        return (which == 0) ? s2m_a[32:1] : s2m_b[32:1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel);
        if (which == 0) m2s_a = {addr, wdata, sel, we, 1'b1, 1'b1};
        else            m2s_b = {addr, wdata, sel, we, 1'b1, 1'b1};
    endtask

    task automatic idle(input int which);
        if (which == 0) m2s_a = '0;
        else            m2s_b = '0;
    endtask

    // One full access: request cycle, ack cycle, then ack must be gone
    task automatic xfer(input int which, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        output logic [31:0] rd);
        drive(which, we, addr, wdata, sel);
        check("ack_before_edge", {31'h0, ack_of(which)}, 32'h0);
        tick();
        check("ack_one_cycle", {31'h0, ack_of(which)}, 32'h1);
        rd = rd_of(which);
        idle(which);
        tick();
        check("ack_dropped", {31'h0, ack_of(which)}, 32'h0);
        check("rdata_idle_zero", rd_of(which), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] din_val;

        tbl[0]  = '{1'b0, 32'h4000_0004 | GPIO_DIR, 32'h0, 4'hF, 1'b1, 32'h0000_00FF, 32'h0000_00A5, 32'h0000_00FF};
        tbl[1]  = '{1'b0, GPIO_DATA_OUT,   32'h0,          4'hF, 1'b1, 32'h0000_00A5, 32'h0000_00A5, 32'h0000_00FF};
        tbl[2]  = '{1'b1, GPIO_DATA_OUT,   32'h0,          4'hF, 1'b0, 32'h0,         32'h0,         32'h0000_00FF};
        tbl[3]  = '{1'b1, GPIO_DATA_OUT,   32'h1122_3344,  4'h4, 1'b0, 32'h0,         32'h0022_0000, 32'h0000_00FF};
        tbl[4]  = '{1'b1, GPIO_DATA_OUT,   32'hFFFF_FFFF,  4'h0, 1'b0, 32'h0,         32'h0022_0000, 32'h0000_00FF};
        tbl[5]  = '{1'b0, GPIO_DATA_OUT,   32'h0,          4'hF, 1'b1, 32'h0022_0000, 32'h0022_0000, 32'h0000_00FF};
        tbl[6]  = '{1'b1, GPIO_DATA_OUT,   32'hAABB_CCDD,  4'h9, 1'b0, 32'h0,         32'hAA22_00DD, 32'h0000_00FF};
        tbl[7]  = '{1'b1, GPIO_DIR,        32'h1234_5678,  4'hA, 1'b0, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[8]  = '{1'b0, GPIO_DIR,        32'h0,          4'hF, 1'b1, 32'h1200_56FF, 32'hAA22_00DD, 32'h1200_56FF};
        tbl[9]  = '{1'b1, GPIO_IRQ_EN,     32'h0000_FFFF,  4'hF, 1'b0, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[10] = '{1'b0, GPIO_IRQ_EN,     32'h0,          4'hF, 1'b1, 32'h0000_FFFF, 32'hAA22_00DD, 32'h1200_56FF};
        tbl[11] = '{1'b1, GPIO_IRQ_RISE,   32'h0000_0005,  4'hF, 1'b0, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[12] = '{1'b0, GPIO_IRQ_RISE,   32'h0,          4'hF, 1'b1, 32'h0000_0005, 32'hAA22_00DD, 32'h1200_56FF};
        tbl[13] = '{1'b1, GPIO_IRQ_FALL,   32'hC000_0000,  4'h8, 1'b0, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[14] = '{1'b0, GPIO_IRQ_FALL,   32'h0,          4'hF, 1'b1, 32'hC000_0000, 32'hAA22_00DD, 32'h1200_56FF};
        tbl[15] = '{1'b0, GPIO_DATA_IN,    32'h0,          4'hF, 1'b1, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[16] = '{1'b0, GPIO_IRQ_STATUS, 32'h0,          4'hF, 1'b1, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[17] = '{1'b1, GPIO_RESERVED,   32'hFFFF_FFFF,  4'hF, 1'b0, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[18] = '{1'b0, GPIO_RESERVED,   32'h0,          4'hF, 1'b1, 32'h0,         32'hAA22_00DD, 32'h1200_56FF};
        tbl[19] = '{1'b0, GPIO_DATA_OUT,   32'h0,          4'hF, 1'b1, 32'hAA22_00DD, 32'hAA22_00DD, 32'h1200_56FF};

        rstn_a    = 1'b0;
        rstn_b    = 1'b0;
        m2s_a     = '0;
        m2s_b     = '0;
        gpio_in_a = '0;
        gpio_in_b = '0;
        repeat (3) tick();
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        tick();

        // Reset state
        check("rst_gpio_a", gpio_out_a, 32'h0000_00A5);
        check("rst_oe_a",   gpio_oe_a,  32'h0000_00FF);
        check("rst_irq_a",  {31'h0, irq_a}, 32'h0);
        check("rst_ack_a",  {31'h0, ack_of(0)}, 32'h0);
        check("rst_rd_a",   rd_of(0), 32'h0);
        check("rst_gpio_b", {24'h0, gpio_out_b}, 32'h0);
        check("rst_oe_b",   {24'h0, gpio_oe_b},  32'h0);

        // Register access table
        for (int i = 0; i < NVEC; i++) begin
            xfer(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel, rd);
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_gpio", i), gpio_out_a, tbl[i].exp_gpio);
            check($sformatf("vec%0d_oe", i),   gpio_oe_a,  tbl[i].exp_oe);
            check($sformatf("vec%0d_irq", i),  {31'h0, irq_a}, 32'h0);
        end

        // Input synchroniser latency, interrupts disabled
        xfer(0, 1'b1, GPIO_IRQ_EN, 32'h0, 4'hF, rd);
        din_val = 32'h8000_0001;
        for (int c = 0; c < 4; c++) begin
            gpio_in_a = '0;
            repeat (4) tick();
            gpio_in_a = din_val;
            repeat (c) tick();
            drive(0, 1'b0, GPIO_DATA_IN, 32'h0, 4'hF);
            tick();
            check($sformatf("sync_ack_c%0d", c), {31'h0, ack_of(0)}, 32'h1);
            check($sformatf("sync_din_c%0d", c), rd_of(0), (c >= SYNC_N) ? din_val : 32'h0);
            idle(0);
            tick();
        end
        gpio_in_a = '0;
        repeat (4) tick();
        xfer(0, 1'b0, GPIO_IRQ_STATUS, 32'h0, 4'hF, rd);
        check("status_en_off", rd, 32'h0);

        // Rising edge interrupt on pin 3
        xfer(0, 1'b1, GPIO_IRQ_EN,     32'h8,         4'hF, rd);
        xfer(0, 1'b1, GPIO_IRQ_RISE,   32'h8,         4'hF, rd);
        xfer(0, 1'b1, GPIO_IRQ_FALL,   32'h0,         4'hF, rd);
        xfer(0, 1'b1, GPIO_IRQ_STATUS, 32'hFFFF_FFFF, 4'hF, rd);
        check("irq_cfg_no_set", {31'h0, irq_a}, 32'h0);
        gpio_in_a = 32'h8;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("rise_irq_c%0d", c), {31'h0, irq_a}, 32'h0);
        end
        drive(0, 1'b0, GPIO_IRQ_STATUS, 32'h0, 4'hF);
        tick();
        check("rise_status_c3", rd_of(0), 32'h8);
        check("rise_irq_c4", {31'h0, irq_a}, 32'h1);
        idle(0);
        tick();

        // Write-1-to-clear, then a falling edge that must not set status
        drive(0, 1'b1, GPIO_IRQ_STATUS, 32'h8, 4'hF);
        tick();
        check("w1c_ack", {31'h0, ack_of(0)}, 32'h1);
        check("w1c_irq_still", {31'h0, irq_a}, 32'h1);
        idle(0);
        tick();
        check("w1c_irq_clear", {31'h0, irq_a}, 32'h0);
        gpio_in_a = 32'h0;
        repeat (5) tick();
        check("fall_irq", {31'h0, irq_a}, 32'h0);
        xfer(0, 1'b0, GPIO_IRQ_STATUS, 32'h0, 4'hF, rd);
        check("fall_status", rd, 32'h0);

        // Clear colliding with a new rise on pin 0
        xfer(0, 1'b1, GPIO_IRQ_EN,   32'h1, 4'hF, rd);
        xfer(0, 1'b1, GPIO_IRQ_RISE, 32'h1, 4'hF, rd);
        gpio_in_a = 32'h1;
        repeat (5) tick();
        check("coll_pre_irq", {31'h0, irq_a}, 32'h1);
        gpio_in_a = 32'h0;
        repeat (4) tick();
        gpio_in_a = 32'h1;
        repeat (SYNC_N) tick();
        drive(0, 1'b1, GPIO_IRQ_STATUS, 32'h1, 4'hF);
        tick();
        check("coll_ack", {31'h0, ack_of(0)}, 32'h1);
        check("coll_irq_a", {31'h0, irq_a}, 32'h1);
        idle(0);
        tick();
        check("coll_irq_b", {31'h0, irq_a}, 32'h1);
        xfer(0, 1'b0, GPIO_IRQ_STATUS, 32'h0, 4'hF, rd);
        check("coll_status", rd, 32'h1);

        // Disabling the enable masks the line but keeps status
        xfer(0, 1'b1, GPIO_IRQ_EN, 32'h0, 4'hF, rd);
        check("en_off_irq", {31'h0, irq_a}, 32'h0);
        xfer(0, 1'b0, GPIO_IRQ_STATUS, 32'h0, 4'hF, rd);
        check("en_off_status", rd, 32'h1);

        // Narrow instance: upper bits read 0 and ignore writes
        xfer(1, 1'b1, GPIO_DIR, 32'hFFFF_FFFF, 4'hF, rd);
        check("b_oe", {24'h0, gpio_oe_b}, 32'h0000_00FF);
        xfer(1, 1'b0, GPIO_DIR, 32'h0, 4'hF, rd);
        check("b_dir_rd", rd, 32'h0000_00FF);
        xfer(1, 1'b1, GPIO_DATA_OUT, 32'h1234_5678, 4'hF, rd);
        check("b_gpio", {24'h0, gpio_out_b}, 32'h0000_0078);
        xfer(1, 1'b0, GPIO_DATA_OUT, 32'h0, 4'hF, rd);
        check("b_out_rd", rd, 32'h0000_0078);
        xfer(1, 1'b0, GPIO_RESERVED, 32'h0, 4'hF, rd);
        check("b_rsvd_rd", rd, 32'h0);
        gpio_in_b = 8'h5A;
        repeat (3) tick();
        xfer(1, 1'b0, GPIO_DATA_IN, 32'h0, 4'hF, rd);
        check("b_din_rd", rd, 32'h0000_005A);

        // Reset during the request cycle: no ack may follow release
        drive(1, 1'b0, GPIO_DIR, 32'h0, 4'hF);
        #2;
        rstn_b = 1'b0;
        #1;
        idle(1);
        check("b_rst_req_ack", {31'h0, ack_of(1)}, 32'h0);
        repeat (2) tick();
        rstn_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("b_post_rst_ack%0d", c), {31'h0, ack_of(1)}, 32'h0);
        end
        check("b_post_rst_oe", {24'h0, gpio_oe_b}, 32'h0);
        xfer(1, 1'b0, GPIO_DIR, 32'h0, 4'hF, rd);
        check("b_post_rst_dir", rd, 32'h0);

        // Reset while ack is high drops it immediately
        drive(1, 1'b0, GPIO_DATA_OUT, 32'h0, 4'hF);
        tick();
        check("b_ack_high", {31'h0, ack_of(1)}, 32'h1);
        rstn_b = 1'b0;
        #1;
        check("b_ack_async_drop", {31'h0, ack_of(1)}, 32'h0);
        idle(1);
        tick();
        rstn_b = 1'b1;
        tick();
        check("b_ack_after_release", {31'h0, ack_of(1)}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
